// File: rtl/uart_xmit_arb.sv
// uart_xmit_arb
//
// Round-robin arbiter in front of a single UART transmitter. Four requesters
// hold a level request with their byte until acked; the winner's byte is
// latched onto xmit_dataH, xmitH is raised as a start request, and the
// transmitter handshake (xmit_doneH low while sending, high when idle) is
// followed to the end of the frame. An optional idle gap of GAP_CYCLES clocks
// separates frames.
//
// Build option:
//   UART_ARB_TIMEOUT_EN  when defined, each wait state is bounded by TIMEOUT
//                        clocks; expiry drops xmitH, pulses errH and moves on
//                        to the gap. When undefined, waits are unbounded and
//                        errH is tied low.
//
// Ports:
//   sys_clk      in   1   clock, rising edge
//   sys_rst_l    in   1   asynchronous active-low reset
//   reqH         in   4   per-requester level request
//   req_dataH    in  32   byte of requester i on bits [8i+7:8i]
//   ackH         out  4   one-cycle pulse, byte of requester i accepted
//   xmitH        out  1   start request to the transmitter
//   xmit_dataH   out  8   byte presented to the transmitter
//   xmit_doneH   in   1   transmitter idle (1) / sending (0)
//   busyH        out  1   arbiter not in IDLE
//   grant_idH    out  2   index of last granted requester
//   errH         out  1   one-cycle pulse on timeout abort
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a request while the transmitter is idle
// WAIT_BUSY | xmitH high, waiting for the transmitter to go busy
// WAIT_DONE | frame in flight, waiting for the transmitter to go idle
// GAP       | enforced idle clocks before the next grant

module uart_xmit_arb #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic        sys_clk,
    input  logic        sys_rst_l,
    input  logic [3:0]  reqH,
    input  logic [31:0] req_dataH,
    output logic [3:0]  ackH,
    output logic        xmitH,
    output logic [7:0]  xmit_dataH,
    input  logic        xmit_doneH,
    output logic        busyH,
    output logic [1:0]  grant_idH,
    output logic        errH
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arbStateT;

    arbStateT         state;
    arbStateT         nextState;
    logic             nextXmit;
    logic [7:0]       nextData;
    logic [3:0]       nextAck;
    logic [1:0]       nextGrant;
    logic [GAP_W-1:0] gapCnt;
    logic [GAP_W-1:0] nextGapCnt;
    logic             frameEnd;

    logic             winnerFound;
    logic [1:0]       winner;
    logic [1:0]       cand;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Abort fires on the edge where the count has already spent TIMEOUT-1
    // clocks in the state, so errH appears exactly TIMEOUT clocks after entry.
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] nextWaitCnt;
    logic              nextErr;
`endif

    assign busyH = (state != IDLE);

    // Round-robin search: candidates grant+1, grant+2, grant+3, grant+0.
    always_comb begin
        winnerFound = 1'b0;
        winner      = grant_idH;
        cand        = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = grant_idH + 2'(i);
            if (!winnerFound && reqH[cand]) begin
                winnerFound = 1'b1;
                winner      = cand;
            end
        end
    end

    always_comb begin
        nextState  = state;
        nextXmit   = xmitH;
        nextData   = xmit_dataH;
        nextAck    = 4'b0000;
        nextGrant  = grant_idH;
        nextGapCnt = gapCnt;
        frameEnd   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        nextWaitCnt = waitCnt;
        nextErr     = 1'b0;
`endif

        unique case (state)
            IDLE: begin
                if (winnerFound && xmit_doneH) begin
                    nextData  = req_dataH[{winner, 3'b000} +: 8];
                    nextAck   = 4'b0001 << winner;
                    nextGrant = winner;
                    nextXmit  = 1'b1;
                    nextState = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    nextWaitCnt = '0;
`endif
                end
            end

            WAIT_BUSY: begin
                if (!xmit_doneH) begin
                    nextXmit  = 1'b0;
                    nextState = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    nextWaitCnt = '0;
                end else if (waitCnt == WAIT_LIMIT) begin
                    nextXmit = 1'b0;
                    nextErr  = 1'b1;
                    frameEnd = 1'b1;
                end else begin
                    nextWaitCnt = waitCnt + WAIT_ONE;
`endif
                end
            end

            WAIT_DONE: begin
                if (xmit_doneH) begin
                    frameEnd = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (waitCnt == WAIT_LIMIT) begin
                    nextXmit = 1'b0;
                    nextErr  = 1'b1;
                    frameEnd = 1'b1;
                end else begin
                    nextWaitCnt = waitCnt + WAIT_ONE;
`endif
                end
            end

            GAP: begin
                // Leave on the clock the counter hits zero; never wraps.
                if (gapCnt <= GAP_ONE) begin
                    nextGapCnt = '0;
                    nextState  = IDLE;
                end else begin
                    nextGapCnt = gapCnt - GAP_ONE;
                end
            end

            default: begin
                nextState = IDLE;
            end
        endcase

        if (frameEnd) begin
            if (GAP_CYCLES == 0) begin
                nextState = IDLE;
            end else begin
                nextState  = GAP;
                nextGapCnt = GAP_LOAD;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= IDLE;
            xmitH      <= 1'b0;
            xmit_dataH <= 8'h00;
            ackH       <= 4'b0000;
            grant_idH  <= 2'd3;
            gapCnt     <= '0;
        end else begin
            state      <= nextState;
            xmitH      <= nextXmit;
            xmit_dataH <= nextData;
            ackH       <= nextAck;
            grant_idH  <= nextGrant;
            gapCnt     <= nextGapCnt;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            waitCnt <= '0;
            errH    <= 1'b0;
        end else begin
            waitCnt <= nextWaitCnt;
            errH    <= nextErr;
        end
    end
`else
    assign errH = 1'b0;
`endif

endmodule
